// File: rtl/renkon_linebuf_pad.sv
// Rotating line-buffer datapath: BUFLINE banks feed a MAXFIL x MAXFIL padded window.
// Optional macro RENKON_LINEBUF_MASK_EN adds buf_mask to blank leading rows/columns for small kernels.

module renkon_linebuf_bank #(
    parameter int DWIDTH    = 16,
    parameter int BUFSIZE   = 33,
    parameter int SIZEWIDTH = 6
) (
    input  logic                 clk,
    input  logic                 xrst,
    input  logic                 we,
    input  logic [SIZEWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0]    wdata,
    output logic [DWIDTH-1:0]    rdata
);
    logic [DWIDTH-1:0] mem [BUFSIZE];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
    end

    // Read-first: a same-cycle write to addr is not visible until the next read.
    always_ff @(posedge clk) begin
        if (!xrst)
            rdata <= '0;
        else
            rdata <= mem[addr];
    end
endmodule

module renkon_linebuf_pad #(
    parameter  int DWIDTH    = 16,
    parameter  int MAXFIL    = 3,
    parameter  int MAXIMG    = 32,
    localparam int BUFSIZE   = MAXIMG + 1,
    localparam int BUFLINE   = MAXFIL + 1,
    localparam int SIZEWIDTH = $clog2(BUFSIZE),
    localparam int LINEWIDTH = $clog2(BUFLINE)
) (
    input  logic                                    clk,
    input  logic                                    xrst,
    input  logic [DWIDTH-1:0]                       buf_input,
    input  logic                                    buf_we,
    input  logic [SIZEWIDTH-1:0]                    buf_addr,
    input  logic                                    buf_wcol,
    input  logic [LINEWIDTH:0]                      buf_wsel,
    input  logic [LINEWIDTH:0]                      buf_rsel,
    input  logic [MAXFIL-1:0]                       buf_rrow,
`ifdef RENKON_LINEBUF_MASK_EN
    input  logic [MAXFIL-1:0]                       buf_mask,
`endif
    output logic [MAXFIL*MAXFIL-1:0][DWIDTH-1:0]    buf_output
);
    localparam logic [LINEWIDTH:0] NLINE = (LINEWIDTH+1)'(BUFLINE);

    logic [BUFLINE-1:0][DWIDTH-1:0]             rd_q;
    logic [MAXFIL-1:0][DWIDTH-1:0]              row_d;
    logic [MAXFIL-1:0][DWIDTH-1:0]              sel_q;
    logic [MAXFIL-1:0][MAXFIL-1:0][DWIDTH-1:0]  win_q;   // [column][row]
    logic [DWIDTH-1:0]                          wdata;
    logic                                       rsel_ok;

    assign wdata   = buf_wcol ? buf_input : '0;
    assign rsel_ok = buf_rsel < NLINE;

    // Writes are held off while in reset; wsel outside 1..BUFLINE matches no bank.
    for (genvar b = 0; b < BUFLINE; b++) begin : g_bank
        logic bank_we;
        assign bank_we = buf_we && xrst && (buf_wsel == (LINEWIDTH+1)'(b + 1));

        renkon_linebuf_bank #(
            .DWIDTH    (DWIDTH),
            .BUFSIZE   (BUFSIZE),
            .SIZEWIDTH (SIZEWIDTH)
        ) u_bank (
            .clk   (clk),
            .xrst  (xrst),
            .we    (bank_we),
            .addr  (buf_addr),
            .wdata (wdata),
            .rdata (rd_q[b])
        );
    end

    // Row j is the bank (rsel+1+j) mod BUFLINE; the sum never reaches 2*BUFLINE when rsel is valid.
    for (genvar j = 0; j < MAXFIL; j++) begin : g_row
        localparam logic [LINEWIDTH:0] OFS = (LINEWIDTH+1)'(j + 1);
        logic [LINEWIDTH:0]   sum;
        logic [LINEWIDTH-1:0] idx;

        assign sum      = buf_rsel + OFS;
        assign idx      = LINEWIDTH'((sum >= NLINE) ? sum - NLINE : sum);
        assign row_d[j] = (rsel_ok && buf_rrow[j]) ? rd_q[idx] : '0;
    end

    always_ff @(posedge clk) begin
        if (!xrst) begin
            sel_q <= '0;
            win_q <= '0;
        end else begin
            sel_q             <= row_d;
            win_q[MAXFIL-1]   <= sel_q;
            for (int k = 0; k < MAXFIL - 1; k++)
                win_q[k] <= win_q[k+1];
        end
    end

    for (genvar i = 0; i < MAXFIL; i++) begin : g_out_row
        for (genvar k = 0; k < MAXFIL; k++) begin : g_out_col
`ifdef RENKON_LINEBUF_MASK_EN
            assign buf_output[i*MAXFIL+k] = (buf_mask[i] || buf_mask[k]) ? '0 : win_q[k][i];
`else
            assign buf_output[i*MAXFIL+k] = win_q[k][i];
`endif
        end
    end
endmodule

// File: tb/tb_renkon_linebuf_pad.sv
// Table-driven bench for renkon_linebuf_pad (MAXFIL=3, BUFLINE=4, DWIDTH=16).
// Builds mask vectors only when RENKON_LINEBUF_MASK_EN is defined.

module tb_renkon_linebuf_pad;
    localparam int DW = 16;
    localparam int MF = 3;

    logic                  clk = 1'b0;
    logic                  xrst;
    logic [DW-1:0]         buf_input;
    logic                  buf_we;
    logic [5:0]            buf_addr;
    logic                  buf_wcol;
    logic [2:0]            buf_wsel;
    logic [2:0]            buf_rsel;
    logic [MF-1:0]         buf_rrow;
`ifdef RENKON_LINEBUF_MASK_EN
    logic [MF-1:0]         buf_mask;
`endif
    logic [MF*MF-1:0][DW-1:0] buf_output;

    always #5 clk = ~clk;

    renkon_linebuf_pad #(.DWIDTH(DW), .MAXFIL(MF), .MAXIMG(32)) dut (
        .clk        (clk),
        .xrst       (xrst),
        .buf_input  (buf_input),
        .buf_we     (buf_we),
        .buf_addr   (buf_addr),
        .buf_wcol   (buf_wcol),
        .buf_wsel   (buf_wsel),
        .buf_rsel   (buf_rsel),
        .buf_rrow   (buf_rrow),
`ifdef RENKON_LINEBUF_MASK_EN
        .buf_mask   (buf_mask),
`endif
        .buf_output (buf_output)
    );

    // One record per cycle: inputs, then up to three element checks after that edge.
    // idx 9 means every window element must equal the expected value.
    typedef struct packed {
        logic            xrst;
        logic            we;
        logic [2:0]      wsel;
        logic            wcol;
        logic [5:0]      addr;
        logic [15:0]     din;
        logic [2:0]      rsel;
        logic [2:0]      rrow;
        logic [2:0]      mask;
        logic [1:0]      nchk;
        logic [2:0][3:0] idx;
        logic [2:0][15:0] exp;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input int x, input int we, input int wsel, input int wcol,
                       input int addr, input int din, input int rsel, input int rrow,
                       input int mask, input int n, input int i0, input int e0,
                       input int i1, input int e1, input int i2, input int e2);
        vec_t v;
        v.xrst   = 1'(x);
        v.we     = 1'(we);
        v.wsel   = 3'(wsel);
        v.wcol   = 1'(wcol);
        v.addr   = 6'(addr);
        v.din    = 16'(din);
        v.rsel   = 3'(rsel);
        v.rrow   = 3'(rrow);
        v.mask   = 3'(mask);
        v.nchk   = 2'(n);
        v.idx[0] = 4'(i0);
        v.exp[0] = 16'(e0);
        v.idx[1] = 4'(i1);
        v.exp[1] = 16'(e1);
        v.idx[2] = 4'(i2);
        v.exp[2] = 16'(e2);
        tbl.push_back(v);
    endtask

    task automatic wr(input int wsel, input int wcol, input int addr, input int din);
        add(1, 1, wsel, wcol, addr, din, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rd(input int addr, input int rsel, input int rrow, input int n,
                      input int i0, input int e0, input int i1, input int e1,
                      input int i2, input int e2);
        add(1, 0, 0, 0, addr, 0, rsel, rrow, 0, n, i0, e0, i1, e1, i2, e2);
    endtask

    task automatic check(input int n, input int idx, input logic [15:0] exp);
        int bad;
        checks++;
        bad = -1;
        if (idx == 9) begin
            for (int e = 0; e < MF*MF; e++)
                if (buf_output[e] !== exp && bad < 0) bad = e;
        end else if (buf_output[idx] !== exp) begin
            bad = idx;
        end
        if (bad >= 0) begin
            errors++;
            $display("FAIL vec%0d elem%0d: got %h expected %h", n, bad, buf_output[bad], exp);
        end
    endtask

    initial begin
        // Reset with writes attempted: window must stay zero.
        add(0, 1, 1, 1, 0, 16'h55, 0, 7, 0, 1, 9, 0, 0, 0, 0, 0);
        add(0, 1, 1, 1, 0, 16'h55, 0, 7, 0, 1, 9, 0, 0, 0, 0, 0);
        // Zero-fill the used addresses with wcol=0 so nothing is undefined.
        for (int a = 0; a < 8; a++)
            for (int w = 1; w <= 4; w++)
                wr(w, 0, a, 16'hAAAA);
        rd(0, 4, 7, 1, 9, 0, 0, 0, 0, 0);

        // Write 5 into line 2 addr 7, then read it: read-first, then 2-edge latency.
        wr(2, 1, 7, 5);
        rd(7, 0, 7, 1, 2, 0, 0, 0, 0, 0);
        rd(7, 0, 7, 1, 2, 0, 0, 0, 0, 0);
        rd(7, 0, 7, 2, 2, 5, 5, 0, 0, 0);
        rd(7, 0, 7, 1, 1, 5, 0, 0, 0, 0);
        rd(7, 0, 7, 1, 0, 5, 0, 0, 0, 0);

        // Padding column write replaces 0x77 with zero; rsel=3 wraps to bank 0.
        wr(1, 1, 3, 16'h77);
        wr(1, 0, 3, 9);
        rd(3, 3, 7, 0, 0, 0, 0, 0, 0, 0);
        rd(3, 3, 7, 1, 2, 16'h77, 0, 0, 0, 0);
        rd(3, 3, 7, 1, 2, 0, 0, 0, 0, 0);

        // Banks 1/2/3/4 at addr 0, rrow=101: rows 2,0,4; bank 3 first seen old.
        wr(1, 1, 0, 1);
        wr(2, 1, 0, 2);
        wr(3, 1, 0, 3);
        wr(4, 1, 0, 4);
        rd(0, 0, 5, 0, 0, 0, 0, 0, 0, 0);
        rd(0, 0, 5, 2, 2, 2, 8, 0, 0, 0);
        rd(0, 0, 5, 2, 2, 2, 8, 4, 0, 0);
        rd(0, 0, 5, 1, 5, 0, 0, 0, 0, 0);
        // rsel out of range zeroes every row.
        rd(0, 4, 7, 0, 0, 0, 0, 0, 0, 0);
        rd(0, 4, 7, 1, 2, 0, 0, 0, 0, 0);
        rd(0, 4, 7, 1, 1, 0, 0, 0, 0, 0);
        rd(0, 4, 7, 1, 9, 0, 0, 0, 0, 0);

        // Shift: 1,2,3 read on consecutive cycles land in row 0 columns 0..2.
        wr(2, 1, 0, 1);
        wr(2, 1, 1, 2);
        wr(2, 1, 2, 3);
        rd(0, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        rd(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        rd(2, 0, 7, 1, 2, 1, 0, 0, 0, 0);
        rd(0, 0, 7, 2, 2, 2, 1, 1, 0, 0);
        rd(0, 4, 7, 3, 0, 1, 1, 2, 2, 3);

        // Same-address read and write in one cycle returns the old word.
        add(1, 1, 2, 1, 1, 16'h99, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        rd(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
        rd(1, 0, 7, 1, 2, 2, 0, 0, 0, 0);
        rd(1, 0, 7, 1, 2, 16'h99, 0, 0, 0, 0);

        // Mid-stream reset clears the pipeline; data refills after 3 edges.
        add(0, 0, 0, 0, 1, 0, 0, 7, 0, 1, 9, 0, 0, 0, 0, 0);
        rd(1, 0, 7, 1, 9, 0, 0, 0, 0, 0);
        rd(1, 0, 7, 1, 2, 0, 0, 0, 0, 0);
        rd(1, 0, 7, 1, 2, 16'h99, 0, 0, 0, 0);

`ifdef RENKON_LINEBUF_MASK_EN
        for (int w = 1; w <= 4; w++)
            wr(w, 1, 10, 7);
        for (int c = 0; c < 4; c++)
            add(1, 0, 0, 0, 10, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 10, 0, 0, 7, 0, 1, 9, 7, 0, 0, 0, 0);
        add(1, 0, 0, 0, 10, 0, 0, 7, 1, 3, 0, 0, 3, 0, 4, 7);
        add(1, 0, 0, 0, 10, 0, 0, 7, 1, 2, 8, 7, 1, 0, 0, 0);
`endif

        for (int n = 0; n < tbl.size(); n++) begin
            xrst      = tbl[n].xrst;
            buf_we    = tbl[n].we;
            buf_wsel  = tbl[n].wsel;
            buf_wcol  = tbl[n].wcol;
            buf_addr  = tbl[n].addr;
            buf_input = tbl[n].din;
            buf_rsel  = tbl[n].rsel;
            buf_rrow  = tbl[n].rrow;
`ifdef RENKON_LINEBUF_MASK_EN
            buf_mask  = tbl[n].mask;
`endif
            @(posedge clk);
            #1;
            for (int c = 0; c < int'(tbl[n].nchk); c++)
                check(n, int'(tbl[n].idx[c]), tbl[n].exp[c]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
